product_accumulator: RTL and testbench

//  Downstream consumer of the 16x16 array multiplier. Accepts a stream of unsigned
//  32-bit products over a valid/ready handshake and sums COUNT products per frame.

---
 rtl/product_accumulator.sv | 115 +++++++++++
 tb/tb_product_accumulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Frame-based accumulator for unsigned multiplier products: sums COUNT accepted
// products per frame and holds the total (with sticky carry-out flag) until taken.
module product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int COUNT  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    // state  | meaning
    // IDLE   | no partial sum, cnt == 0
    // ACC    | 1..COUNT-1 products summed
    // HOLD   | completed frame presented on the output port
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic [ACC_W-1:0] acc_base;
    logic             flag_base;
    logic [ACC_W:0]   sum_ext;

    always_comb begin
        accept    = in_valid && (state_q != S_HOLD) && !clr;
        // IDLE starts a fresh frame regardless of any stale accumulator contents
        acc_base  = (state_q == S_IDLE) ? '0 : acc_q;
        flag_base = (state_q == S_IDLE) ? 1'b0 : flag_q;
        sum_ext   = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            flag_d      = 1'b0;
            out_valid_d = 1'b0;
        end else if (state_q == S_HOLD) begin
            if (out_ready) begin
                state_d     = S_IDLE;
                acc_d       = '0;
                flag_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (cnt_q == CNT_LAST) begin
                out_sum_d   = sum_ext[ACC_W-1:0];
                out_ovf_d   = flag_base | sum_ext[ACC_W];
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_d       = '0;
                flag_d      = 1'b0;
                state_d     = S_HOLD;
            end else begin
                acc_d   = sum_ext[ACC_W-1:0];
                flag_d  = flag_base | sum_ext[ACC_W];
                cnt_d   = cnt_q + 1'b1;
                state_d = S_ACC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q != S_HOLD);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three configurations (default, ACC_W=33, COUNT=1)
// checked every cycle against a frame-level arithmetic model plus literal spot checks.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv   = '0;
    logic [2:0]  cl   = '0;
    logic [2:0]  ordy = 3'b111;
    logic [31:0] ip [3];

    logic [2:0]  a_ready, a_valid, a_ovf;
    logic [39:0] os0;
    logic [32:0] os1;
    logic [39:0] os2;
    logic [63:0] a_sum [3];

    int total = 0;
    int bad   = 0;
    bit go    = 1'b0;

    always #5 clk = ~clk;

    product_accumulator u0 (
        .clk(clk), .rst(rst), .clr(cl[0]), .in_valid(iv[0]), .in_ready(a_ready[0]),
        .in_prod(ip[0]), .out_valid(a_valid[0]), .out_ready(ordy[0]),
        .out_sum(os0), .out_ovf(a_ovf[0])
    );

    product_accumulator #(.ACC_W(33)) u1 (
        .clk(clk), .rst(rst), .clr(cl[1]), .in_valid(iv[1]), .in_ready(a_ready[1]),
        .in_prod(ip[1]), .out_valid(a_valid[1]), .out_ready(ordy[1]),
        .out_sum(os1), .out_ovf(a_ovf[1])
    );

    product_accumulator #(.COUNT(1)) u2 (
        .clk(clk), .rst(rst), .clr(cl[2]), .in_valid(iv[2]), .in_ready(a_ready[2]),
        .in_prod(ip[2]), .out_valid(a_valid[2]), .out_ready(ordy[2]),
        .out_sum(os2), .out_ovf(a_ovf[2])
    );

    assign a_sum[0] = 64'(os0);
    assign a_sum[1] = 64'(os1);
    assign a_sum[2] = 64'(os2);

    // Frame model: plain running total of accepted products, reduced only when presented
    int              count_p [3] = '{4, 4, 1};
    int              accw_p  [3] = '{40, 33, 40};
    int              n_m     [3] = '{0, 0, 0};
    longint unsigned tot_m   [3] = '{0, 0, 0};
    bit              hold_m  [3] = '{0, 0, 0};
    longint unsigned es      [3] = '{0, 0, 0};
    bit              eo      [3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                n_m[i] = 0; tot_m[i] = 0; hold_m[i] = 0; es[i] = 0; eo[i] = 0;
            end else if (cl[i]) begin
                n_m[i] = 0; tot_m[i] = 0; hold_m[i] = 0;
            end else if (hold_m[i]) begin
                if (ordy[i]) hold_m[i] = 0;
            end else if (iv[i]) begin
                tot_m[i] = tot_m[i] + 64'(ip[i]);
                n_m[i]   = n_m[i] + 1;
                if (n_m[i] == count_p[i]) begin
                    es[i]     = tot_m[i] & ((64'd1 << accw_p[i]) - 64'd1);
                    eo[i]     = (tot_m[i] >> accw_p[i]) != 0;
                    hold_m[i] = 1;
                    n_m[i]    = 0;
                    tot_m[i]  = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go && !rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("in_ready%0d", i),  64'(a_ready[i]), 64'(!hold_m[i]));
                chk($sformatf("out_valid%0d", i), 64'(a_valid[i]), 64'(hold_m[i]));
                chk($sformatf("out_sum%0d", i),   a_sum[i], es[i]);
                chk($sformatf("out_ovf%0d", i),   64'(a_ovf[i]), 64'(eo[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ip[0] = '0; ip[1] = '0; ip[2] = '0;
        repeat (2) tick();
        rst = 1'b0;
        go  = 1'b1;

        // 1) reset pulse mid-frame, then a fresh frame 1+2+3+4
        iv[0] = 1'b1; ip[0] = 32'd7;
        repeat (2) tick();
        iv[0] = 1'b0; ip[0] = 32'd1;
        rst = 1'b1;
        tick();
        chk("rst_valid", 64'(a_valid[0]), 64'd0);
        chk("rst_sum",   a_sum[0], 64'd0);
        chk("rst_ready", 64'(a_ready[0]), 64'd1);
        rst = 1'b0;
        iv[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            ip[0] = 32'(k);
            tick();
        end
        iv[0] = 1'b0;
        chk("fresh_sum",   a_sum[0], 64'd10);
        chk("fresh_valid", 64'(a_valid[0]), 64'd1);
        tick();

        // 2)+3) four 0xFFFE0001 products into ACC_W=40 and ACC_W=33
        iv[1:0] = 2'b11; ip[0] = 32'hFFFE0001; ip[1] = 32'hFFFE0001;
        repeat (4) tick();
        iv[1:0] = 2'b00;
        chk("big_sum40", a_sum[0], 64'h3FFF80004);
        chk("big_ovf40", 64'(a_ovf[0]), 64'd0);
        chk("big_vld40", 64'(a_valid[0]), 64'd1);
        chk("big_sum33", a_sum[1], 64'h1FFF80004);
        chk("big_ovf33", 64'(a_ovf[1]), 64'd1);
        chk("model_sum33", es[1], 64'h1FFF80004);
        chk("model_ovf33", 64'(eo[1]), 64'd1);
        tick();
        chk("big_vld_drop", 64'(a_valid[0]), 64'd0);

        // 4) held result with backpressure, ignored in_valid pulses
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ip[0] = 32'd1 << k;
            tick();
        end
        ip[0] = 32'h77;
        for (int k = 0; k < 5; k++) begin
            iv[0] = k[0] ? 1'b0 : 1'b1;
            tick();
            chk("hold_sum",   a_sum[0], 64'd15);
            chk("hold_ready", 64'(a_ready[0]), 64'd0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        tick();
        chk("hold_release", 64'(a_valid[0]), 64'd0);
        iv[0] = 1'b1; ip[0] = 32'd5;
        repeat (4) tick();
        iv[0] = 1'b0;
        chk("after_hold_sum", a_sum[0], 64'd20);
        tick();

        // 5) clr discards the partial sum and beats a simultaneous product
        iv[0] = 1'b1; ip[0] = 32'h10;
        repeat (2) tick();
        cl[0] = 1'b1; ip[0] = 32'h99;
        tick();
        cl[0] = 1'b0; ip[0] = 32'd1;
        repeat (4) tick();
        iv[0] = 1'b0;
        chk("clr_sum",   a_sum[0], 64'd4);
        chk("clr_valid", 64'(a_valid[0]), 64'd1);
        tick();

        // 6) COUNT=1 back-to-back
        iv[2] = 1'b1; ip[2] = 32'd3;
        tick();
        chk("c1_sum3",  a_sum[2], 64'd3);
        chk("c1_ready", 64'(a_ready[2]), 64'd0);
        ip[2] = 32'd5;
        tick();
        chk("c1_gap_valid", 64'(a_valid[2]), 64'd0);
        chk("c1_gap_ready", 64'(a_ready[2]), 64'd1);
        tick();
        iv[2] = 1'b0;
        chk("c1_sum5",   a_sum[2], 64'd5);
        chk("c1_valid5", 64'(a_valid[2]), 64'd1);
        tick();
        chk("c1_end_valid", 64'(a_valid[2]), 64'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
